cc_frame_loader: RTL and testbench

Sequential front end for the combinational comparator/sorter core `CC`. Collects a serial stream of 4-bit operands into a four-operand frame, captures the per-frame 3-bit opt, and presents the frame to `CC` with valid/ready handshaking. It holds the frame stable until the consumer accepts it, then registers `CC`'s 9-bit result for downstream use.

---
 rtl/cc_pkg.sv | 23 ++
 rtl/cc_frame_loader_if.sv | 34 +++
 rtl/cc_frame_loader.sv | 90 +++++++++
 tb/tb_cc_frame_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared constants and types for the CC comparator/sorter core and its frame loader.
package cc_pkg;

    localparam int NUM_W = 4;   // operand width, matches CC in_n*
    localparam int OPT_W = 3;   // opt width, matches CC opt
    localparam int RES_W = 9;   // result width, matches CC out_n
    localparam int CNT_W = 8;   // accepted-frame counter width

    // Meaning of opt bits as interpreted by CC.
    localparam int OPT_BIT_SORT = 0;  // sorted order
    localparam int OPT_BIT_MODE = 1;  // mode select

    typedef logic [NUM_W-1:0] num_t;
    typedef logic [OPT_W-1:0] opt_t;
    typedef logic [RES_W-1:0] res_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/cc_frame_loader_if.sv
// Beat stream, frame presentation and result signals of the CC frame loader.
// master: the loader itself; slave: the producer/consumer/CC environment.
interface cc_frame_loader_if;
    import cc_pkg::*;

    logic   in_valid;
    num_t   in_data;
    opt_t   in_opt;
    logic   in_ready;
    num_t   out_n0;
    num_t   out_n1;
    num_t   out_n2;
    num_t   out_n3;
    opt_t   out_opt;
    logic   frame_valid;
    logic   frame_ready;
    res_t   cc_result;
    res_t   result;
    logic   result_valid;
    cnt_t   frame_cnt;

    modport master (
        input  in_valid, in_data, in_opt, frame_ready, cc_result,
        output in_ready, out_n0, out_n1, out_n2, out_n3, out_opt,
               frame_valid, result, result_valid, frame_cnt
    );

    modport slave (
        output in_valid, in_data, in_opt, frame_ready, cc_result,
        input  in_ready, out_n0, out_n1, out_n2, out_n3, out_opt,
               frame_valid, result, result_valid, frame_cnt
    );

endinterface

// File: rtl/cc_frame_loader.sv
// Collects four serial operand beats into a frame, presents it to CC with a
// valid/ready handshake and registers CC's result when the frame is taken.
module cc_frame_loader
    import cc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cc_frame_loader_if.master  bus
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] beat_idx;
    num_t       ops [4];
    opt_t       opt_q;
    res_t       result_q;
    logic       result_valid_q;
    cnt_t       frame_cnt_q;
    logic       beat_fire;
    logic       frame_fire;
    logic       in_ready_c;
    logic       frame_valid_c;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // Next-state and handshake decode; ready/valid come from state alone.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        in_ready_c    = 1'b0;
        frame_valid_c = 1'b0;
        beat_fire     = 1'b0;
        frame_fire    = 1'b0;
        case (state)
            COLLECT: begin
                in_ready_c = 1'b1;
                beat_fire  = bus.in_valid;
                if (beat_fire && beat_idx == 2'd3) state_nxt = PRESENT;
            end
            PRESENT: begin
                frame_valid_c = 1'b1;
                frame_fire    = bus.frame_ready;
                if (frame_fire) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Operand/opt capture, result register and accepted-frame counter.
    // NOTE: the small operand array is reset because it drives outputs that must read 0 in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx       <= '0;
            for (int i = 0; i < 4; i++) ops[i] <= '0;
            opt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (beat_fire) begin
                ops[beat_idx] <= bus.in_data;
                if (beat_idx == 2'd0) opt_q <= bus.in_opt;
                beat_idx <= beat_idx + 2'd1;  // wraps to 0 after the fourth beat
            end
            if (frame_fire) begin
                result_q       <= bus.cc_result;
                result_valid_q <= 1'b1;
                frame_cnt_q    <= frame_cnt_q + cnt_t'(1);
            end
        end
    end

    assign bus.in_ready     = in_ready_c & ~rst;
    assign bus.frame_valid  = frame_valid_c;
    assign bus.out_n0       = ops[0];
    assign bus.out_n1       = ops[1];
    assign bus.out_n2       = ops[2];
    assign bus.out_n3       = ops[3];
    assign bus.out_opt      = opt_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cc_frame_loader.sv
// Self-checking bench for cc_frame_loader: directed vector table, multi-cycle
// stall and counter-wrap sequences, then randomized traffic against a
// transaction-level reference model.
module tb_cc_frame_loader;
    import cc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   rv_seen = 0;

    cc_frame_loader_if bus ();

    cc_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the CC core: any deterministic function of the frame will do.
    function automatic res_t cc_fn(input num_t a, input num_t b, input num_t c,
                                   input num_t d, input opt_t o);
        res_t r;
        if (o[OPT_BIT_MODE]) r = res_t'(a) + res_t'(b) + res_t'(c) + res_t'(d);
        else                 r = {1'b0, d ^ b, c ^ a};
        if (o[OPT_BIT_SORT]) r = r ^ {o, 6'b0};
        return r;
    endfunction

    assign bus.cc_result = cc_fn(bus.out_n0, bus.out_n1, bus.out_n2, bus.out_n3, bus.out_opt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        vld;
        num_t        dat;
        opt_t        opt;
        logic        frdy;
        logic        e_rdy;
        logic        e_fv;
        logic [15:0] e_n;    // {n3, n2, n1, n0}
        opt_t        e_opt;
        res_t        e_res;
        logic        e_rv;
        cnt_t        e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v, input num_t d, input opt_t o,
                                input logic fr, input logic rdy, input logic fv,
                                input logic [15:0] n, input opt_t eo, input res_t res,
                                input logic rv, input cnt_t cnt);
        vec_t x;
        x.rst = r; x.vld = v; x.dat = d; x.opt = o; x.frdy = fr;
        x.e_rdy = rdy; x.e_fv = fv; x.e_n = n; x.e_opt = eo;
        x.e_res = res; x.e_rv = rv; x.e_cnt = cnt;
        return x;
    endfunction

    // ---------------- reference model ----------------
    num_t m_ops [4];
    num_t m_q[$];       // beats of the frame currently being collected
    opt_t m_opt;
    bit   m_pres;
    res_t m_res;
    bit   m_rv;
    cnt_t m_cnt;

    task automatic model_step(input logic r, input logic v, input num_t d, input opt_t o,
                              input logic fr);
        if (r) begin
            for (int i = 0; i < 4; i++) m_ops[i] = '0;
            m_q.delete();
            m_opt = '0; m_pres = 0; m_res = '0; m_rv = 0; m_cnt = '0;
        end else begin
            m_rv = 0;
            if (!m_pres) begin
                if (v) begin
                    m_ops[m_q.size()] = d;
                    if (m_q.size() == 0) m_opt = o;
                    m_q.push_back(d);
                    if (m_q.size() == 4) begin
                        m_pres = 1;
                        m_q.delete();
                    end
                end
            end else if (fr) begin
                m_res  = cc_fn(m_ops[0], m_ops[1], m_ops[2], m_ops[3], m_opt);
                m_rv   = 1;
                m_cnt  = m_cnt + cnt_t'(1);
                m_pres = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs at the falling edge.
    task automatic cycle(input logic r, input logic v, input num_t d, input opt_t o,
                         input logic fr);
        rst = r; bus.in_valid = v; bus.in_data = d; bus.in_opt = o; bus.frame_ready = fr;
        @(posedge clk);
        model_step(r, v, d, o, fr);
        @(negedge clk);
        check("in_ready", bus.in_ready, (!m_pres && !r));
        check("frame_valid", bus.frame_valid, m_pres);
        check("operands", {bus.out_n3, bus.out_n2, bus.out_n1, bus.out_n0},
              {m_ops[3], m_ops[2], m_ops[1], m_ops[0]});
        check("out_opt", bus.out_opt, m_opt);
        check("result", bus.result, m_res);
        check("result_valid", bus.result_valid, m_rv);
        check("frame_cnt", bus.frame_cnt, m_cnt);
        if (bus.result_valid) rv_seen++;
    endtask

    initial begin
        res_t r1, r2, r3;
        int   rv0;

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_opt = '0; bus.frame_ready = 1'b0;
        @(negedge clk);

        r1 = cc_fn(4'd3, 4'd7, 4'd1, 4'd9, 3'd5);
        r2 = cc_fn(4'd4, 4'd5, 4'd6, 4'd2, 3'd3);
        r3 = cc_fn(4'd4, 4'd4, 4'd0, 4'd15, 3'd6);

        //                  rst vld dat opt fr  rdy fv  ops       opt res rv  cnt
        tbl.push_back(mk(1, 0, 0,  0, 1,  0, 0, 16'h0000, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 3,  5, 1,  1, 0, 16'h0003, 5, 0,  0, 0));
        tbl.push_back(mk(0, 1, 7,  0, 1,  1, 0, 16'h0073, 5, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 1,  1, 0, 16'h0173, 5, 0,  0, 0));
        tbl.push_back(mk(0, 1, 9,  0, 1,  0, 1, 16'h9173, 5, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0, 16'h9173, 5, r1, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0, 16'h9173, 5, r1, 0, 1));
        // beat-0 opt 3, later beats carry other opts that must be ignored
        tbl.push_back(mk(0, 1, 4,  3, 0,  1, 0, 16'h9174, 3, r1, 0, 1));
        tbl.push_back(mk(0, 1, 5,  0, 0,  1, 0, 16'h9154, 3, r1, 0, 1));
        tbl.push_back(mk(0, 1, 6,  7, 0,  1, 0, 16'h9654, 3, r1, 0, 1));
        tbl.push_back(mk(0, 1, 2,  2, 0,  0, 1, 16'h2654, 3, r1, 0, 1));
        tbl.push_back(mk(0, 1, 15, 7, 0,  0, 1, 16'h2654, 3, r1, 0, 1));
        tbl.push_back(mk(0, 1, 15, 7, 1,  1, 0, 16'h2654, 3, r2, 1, 2));
        // partial frame, then reset discards it
        tbl.push_back(mk(0, 1, 8,  1, 0,  1, 0, 16'h2658, 1, r2, 0, 2));
        tbl.push_back(mk(0, 1, 8,  1, 0,  1, 0, 16'h2688, 1, r2, 0, 2));
        tbl.push_back(mk(1, 1, 3,  1, 1,  0, 0, 16'h0000, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4,  6, 0,  1, 0, 16'h0004, 6, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4,  0, 0,  1, 0, 16'h0044, 6, 0,  0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 0,  1, 0, 16'h0044, 6, 0,  0, 0));
        tbl.push_back(mk(0, 1, 15, 0, 0,  0, 1, 16'hF044, 6, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1,  1, 0, 16'hF044, 6, r3, 1, 1));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; bus.in_valid = tbl[i].vld; bus.in_data = tbl[i].dat;
            bus.in_opt = tbl[i].opt; bus.frame_ready = tbl[i].frdy;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d.in_ready", i), bus.in_ready, tbl[i].e_rdy);
            check($sformatf("vec%0d.frame_valid", i), bus.frame_valid, tbl[i].e_fv);
            check($sformatf("vec%0d.operands", i),
                  {bus.out_n3, bus.out_n2, bus.out_n1, bus.out_n0}, tbl[i].e_n);
            check($sformatf("vec%0d.out_opt", i), bus.out_opt, tbl[i].e_opt);
            check($sformatf("vec%0d.result", i), bus.result, tbl[i].e_res);
            check($sformatf("vec%0d.result_valid", i), bus.result_valid, tbl[i].e_rv);
            check($sformatf("vec%0d.frame_cnt", i), bus.frame_cnt, tbl[i].e_cnt);
        end

        // Stall: idle gaps between beats, consumer holds off for 10 cycles while
        // the producer keeps offering 15s, then a single handshake.
        cycle(1, 0, 0, 0, 0);
        for (int b = 0; b < 4; b++) begin
            cycle(0, 1, num_t'(b + 10), (b == 0) ? 3'd6 : 3'd1, 0);
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 10; k++) cycle(0, 1, 4'd15, 3'd7, 0);
        rv0 = rv_seen;
        cycle(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1);
        check("stall_single_handshake", rv_seen - rv0, 1);

        // 256 back-to-back frames at the 5-cycle minimum period.
        cycle(1, 0, 0, 0, 0);
        rv0 = rv_seen;
        for (int f = 0; f < 256; f++)
            for (int b = 0; b < 5; b++)
                cycle(0, 1, num_t'($urandom), opt_t'($urandom), 1);
        check("wrap_pulses", rv_seen - rv0, 256);
        check("wrap_cnt_zero", bus.frame_cnt, 0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
                  num_t'($urandom), opt_t'($urandom), 1'($urandom_range(0, 2) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
